// File: rtl/tone_seq_pkg.sv
// rtl/tone_seq_pkg.sv - shared encodings and score entry layout for the tone sequencer
package tone_seq_pkg;

    // Default widths; the top level re-exposes these as parameters.
    localparam int DEF_NOTE_DIV_W = 20;
    localparam int DEF_DUR_W      = 8;
    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_GAP_TICKS  = 1;

    // Divider value that keeps the note generator silent.
    localparam int SILENCE = 0;

    typedef enum logic [1:0] {
        CMD_PLAY  = 2'd0,
        CMD_PAUSE = 2'd1,
        CMD_STOP  = 2'd2,
        CMD_NEXT  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4,
        ST_PAUSED = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Score entry: note divider in the MSBs, duration in ticks in the LSBs.
    typedef struct packed {
        logic [DEF_NOTE_DIV_W-1:0] note_div;
        logic [DEF_DUR_W-1:0]      dur;
    } entry_t;

endpackage

// File: rtl/seq_tick_counter.sv
// rtl/seq_tick_counter.sv - loadable tick-enabled down-counter with a last-tick flag
module seq_tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_last
);

    logic [W-1:0] r_count;

    // Load wins over decrement; the counter parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == W'(1));

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - commandable tempo-ticked melody scheduler driving the note divider
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int NOTE_DIV_W = DEF_NOTE_DIV_W,
    parameter int DUR_W      = DEF_DUR_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        cmd_valid,
    input  logic [1:0]                  cmd,
    output logic                        cmd_ready,
    input  logic                        loop_en,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [NOTE_DIV_W+DUR_W-1:0] rom_data,
    output logic [NOTE_DIV_W-1:0]       note_div,
    output logic                        playing,
    output logic                        song_done
);

    state_e                r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [NOTE_DIV_W-1:0] r_note_div;
    logic [NOTE_DIV_W-1:0] r_note_latch;
    logic                  r_song_done;
    logic                  r_pause_gap;

    state_e                w_state_nxt;
    logic [ADDR_W-1:0]     w_addr_nxt;
    logic [NOTE_DIV_W-1:0] w_note_nxt;
    logic [NOTE_DIV_W-1:0] w_latch_nxt;
    logic                  w_done_nxt;
    logic                  w_pgap_nxt;
    logic                  w_dur_load;
    logic                  w_dur_en;
    logic                  w_dur_last;
    logic                  w_gap_load;
    logic                  w_gap_en;
    logic                  w_gap_last;
    logic                  w_cmd_acc;
    logic                  w_tick_ok;
    cmd_e                  w_cmd;
    logic [NOTE_DIV_W-1:0] w_entry_note;
    logic [DUR_W-1:0]      w_entry_dur;
    logic [ADDR_W-1:0]     w_addr_inc;

    localparam logic [NOTE_DIV_W-1:0] QUIET = NOTE_DIV_W'(SILENCE);

    assign w_cmd        = cmd_e'(cmd);
    assign cmd_ready    = (r_state != ST_FETCH) && (r_state != ST_LOAD);
    assign w_cmd_acc    = cmd_valid && cmd_ready;
    // An accepted command swallows a coincident tick.
    assign w_tick_ok    = tick && !w_cmd_acc;
    assign w_entry_note = rom_data[NOTE_DIV_W+DUR_W-1:DUR_W];
    assign w_entry_dur  = rom_data[DUR_W-1:0];
    assign w_addr_inc   = r_addr + 1'b1;

    assign rom_addr  = r_addr;
    assign note_div  = r_note_div;
    assign playing   = (r_state == ST_PLAY) || (r_state == ST_GAP);
    assign song_done = r_song_done;

    seq_tick_counter #(.W(DUR_W)) u_dur_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_dur_load),
        .i_load_val (w_entry_dur),
        .i_en       (w_dur_en),
        .o_last     (w_dur_last)
    );

    seq_tick_counter #(.W(DUR_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_gap_load),
        .i_load_val (DUR_W'(GAP_TICKS)),
        .i_en       (w_gap_en),
        .o_last     (w_gap_last)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_note_div   <= '0;
            r_note_latch <= '0;
            r_song_done  <= 1'b0;
            r_pause_gap  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_note_div   <= w_note_nxt;
            r_note_latch <= w_latch_nxt;
            r_song_done  <= w_done_nxt;
            r_pause_gap  <= w_pgap_nxt;
        end
    end

    // Next-state logic: command handling first, then tick-driven progress.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_note_nxt  = r_note_div;
        w_latch_nxt = r_note_latch;
        w_done_nxt  = 1'b0;
        w_pgap_nxt  = r_pause_gap;
        w_dur_load  = 1'b0;
        w_dur_en    = 1'b0;
        w_gap_load  = 1'b0;
        w_gap_en    = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_cmd_acc) begin
                    if (w_cmd == CMD_PLAY) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = ST_FETCH;
                    end else if (w_cmd == CMD_STOP) begin
                        w_addr_nxt  = '0;
                        w_note_nxt  = QUIET;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_FETCH: begin
                w_state_nxt = ST_LOAD;
            end

            ST_LOAD: begin
                if (w_entry_dur != '0) begin
                    w_note_nxt  = w_entry_note;
                    w_latch_nxt = w_entry_note;
                    w_dur_load  = 1'b1;
                    w_state_nxt = ST_PLAY;
                end else if (loop_en && (r_addr != '0)) begin
                    // Restart only from a non-zero address so an empty score cannot spin.
                    w_addr_nxt  = '0;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_note_nxt  = QUIET;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end

            ST_PLAY, ST_GAP: begin
                if (w_cmd_acc) begin
                    case (w_cmd)
                        CMD_PAUSE: begin
                            w_note_nxt  = QUIET;
                            w_pgap_nxt  = (r_state == ST_GAP);
                            w_state_nxt = ST_PAUSED;
                        end
                        CMD_STOP: begin
                            w_addr_nxt  = '0;
                            w_note_nxt  = QUIET;
                            w_state_nxt = ST_IDLE;
                        end
                        CMD_NEXT: begin
                            w_addr_nxt  = w_addr_inc;
                            w_note_nxt  = QUIET;
                            w_state_nxt = ST_FETCH;
                        end
                        default: begin
                        end
                    endcase
                end else if (w_tick_ok && (r_state == ST_PLAY)) begin
                    w_dur_en = 1'b1;
                    if (w_dur_last) begin
                        if (GAP_TICKS > 0) begin
                            w_note_nxt  = QUIET;
                            w_gap_load  = 1'b1;
                            w_state_nxt = ST_GAP;
                        end else begin
                            w_addr_nxt  = w_addr_inc;
                            w_state_nxt = ST_FETCH;
                        end
                    end
                end else if (w_tick_ok) begin
                    w_gap_en = 1'b1;
                    if (w_gap_last) begin
                        w_addr_nxt  = w_addr_inc;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end

            ST_PAUSED: begin
                if (w_cmd_acc) begin
                    case (w_cmd)
                        CMD_PLAY: begin
                            // Resume in whichever phase was interrupted; a paused gap stays silent.
                            w_state_nxt = r_pause_gap ? ST_GAP : ST_PLAY;
                            w_note_nxt  = r_pause_gap ? QUIET : r_note_latch;
                        end
                        CMD_STOP: begin
                            w_addr_nxt  = '0;
                            w_note_nxt  = QUIET;
                            w_state_nxt = ST_IDLE;
                        end
                        CMD_NEXT: begin
                            w_addr_nxt  = w_addr_inc;
                            w_note_nxt  = QUIET;
                            w_state_nxt = ST_FETCH;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - directed self-checking bench for tone_sequencer
module tb_tone_sequencer;
    import tone_seq_pkg::*;

    localparam logic [19:0] NA    = 20'h01234;
    localparam logic [19:0] NB    = 20'h00567;
    localparam logic [19:0] NBASE = 20'h00100;
    localparam logic [19:0] WBASE = 20'h01000;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic        loop_en;
    logic [5:0]  rom_addr;
    logic [27:0] rom_data;
    logic [19:0] note_div;
    logic        playing;
    logic        song_done;

    entry_t rom [64];
    int     n_cmp;
    int     n_bad;

    tone_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .loop_en   (loop_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_div  (note_div),
        .playing   (playing),
        .song_done (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous score ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input cmd_e c);
        cmd_valid = 1'b1;
        cmd       = c;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; tick = 1'b0; cmd_valid = 1'b0; cmd = 2'd0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b1; cmd_valid = 1'b1; cmd = CMD_PLAY; loop_en = 1'b0;
        step(); step();
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        n_cmp++; if (note_div !== 20'd0) begin n_bad++; $display("FAIL reset_note_div got=%h exp=0", note_div); end
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL reset_playing got=%b exp=0", playing); end
        n_cmp++; if (song_done !== 1'b0) begin n_bad++; $display("FAIL reset_song_done got=%b exp=0", song_done); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        tick = 1'b0; cmd_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_play_basic();
        clear_rom();
        rom[0] = '{NA, 8'd2}; rom[1] = '{NB, 8'd1};
        loop_en = 1'b0;
        apply_reset();
        do_cmd(CMD_PLAY);
        n_cmp++; if (dut.r_state !== ST_FETCH) begin n_bad++; $display("FAIL basic_fetch got=%0d exp=%0d", dut.r_state, ST_FETCH); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_fetch got=%b exp=0", cmd_ready); end
        step();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_load got=%b exp=0", cmd_ready); end
        n_cmp++; if (note_div !== 20'd0) begin n_bad++; $display("FAIL basic_note_load got=%h exp=0", note_div); end
        step();
        n_cmp++; if (note_div !== NA) begin n_bad++; $display("FAIL basic_note_a got=%h exp=%h", note_div, NA); end
        n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL basic_playing got=%b exp=1", playing); end
        do_tick();
        n_cmp++; if (note_div !== NA) begin n_bad++; $display("FAIL basic_note_a_t1 got=%h exp=%h", note_div, NA); end
        do_tick();
        n_cmp++; if (note_div !== 20'd0) begin n_bad++; $display("FAIL basic_gap1_note got=%h exp=0", note_div); end
        n_cmp++; if (dut.r_state !== ST_GAP) begin n_bad++; $display("FAIL basic_gap1_state got=%0d exp=%0d", dut.r_state, ST_GAP); end
        n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL basic_gap_playing got=%b exp=1", playing); end
        do_tick();
        n_cmp++; if (rom_addr !== 6'd1) begin n_bad++; $display("FAIL basic_addr1 got=%0d exp=1", rom_addr); end
        step(); step();
        n_cmp++; if (note_div !== NB) begin n_bad++; $display("FAIL basic_note_b got=%h exp=%h", note_div, NB); end
        do_tick();
        n_cmp++; if (note_div !== 20'd0) begin n_bad++; $display("FAIL basic_gap2_note got=%h exp=0", note_div); end
        do_tick();
        step(); step();
        n_cmp++; if (song_done !== 1'b1) begin n_bad++; $display("FAIL basic_done_pulse got=%b exp=1", song_done); end
        n_cmp++; if (dut.r_state !== ST_DONE) begin n_bad++; $display("FAIL basic_done_state got=%0d exp=%0d", dut.r_state, ST_DONE); end
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL basic_done_playing got=%b exp=0", playing); end
        step();
        n_cmp++; if (song_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_once got=%b exp=0", song_done); end
        n_cmp++; if (note_div !== 20'd0) begin n_bad++; $display("FAIL basic_done_note got=%h exp=0", note_div); end
    endtask

    task automatic test_pause_resume();
        clear_rom();
        rom[0] = '{NA, 8'd5};
        loop_en = 1'b0;
        apply_reset();
        do_cmd(CMD_PLAY); step(); step();
        do_tick(); do_tick();
        do_cmd(CMD_PAUSE);
        n_cmp++; if (dut.r_state !== ST_PAUSED) begin n_bad++; $display("FAIL pause_state got=%0d exp=%0d", dut.r_state, ST_PAUSED); end
        n_cmp++; if (note_div !== 20'd0) begin n_bad++; $display("FAIL pause_note got=%h exp=0", note_div); end
        do_tick(); do_tick(); do_tick();
        n_cmp++; if (dut.u_dur_cnt.r_count !== 8'd3) begin n_bad++; $display("FAIL pause_remain got=%0d exp=3", dut.u_dur_cnt.r_count); end
        n_cmp++; if (dut.r_state !== ST_PAUSED) begin n_bad++; $display("FAIL pause_hold got=%0d exp=%0d", dut.r_state, ST_PAUSED); end
        do_cmd(CMD_PLAY);
        n_cmp++; if (note_div !== NA) begin n_bad++; $display("FAIL resume_note got=%h exp=%h", note_div, NA); end
        do_tick(); do_tick();
        n_cmp++; if (note_div !== NA) begin n_bad++; $display("FAIL resume_two_ticks got=%h exp=%h", note_div, NA); end
        do_tick();
        n_cmp++; if (dut.r_state !== ST_GAP) begin n_bad++; $display("FAIL resume_third_tick got=%0d exp=%0d", dut.r_state, ST_GAP); end
    endtask

    task automatic test_stop_next();
        clear_rom();
        for (int k = 0; k < 8; k++) rom[k] = '{NBASE + 20'(k), 8'd3};
        loop_en = 1'b0;
        apply_reset();
        do_cmd(CMD_PLAY); step(); step();
        for (int k = 1; k < 7; k++) begin
            do_cmd(CMD_NEXT);
            n_cmp++; if (rom_addr !== 6'(k)) begin n_bad++; $display("FAIL next_addr%0d got=%0d exp=%0d", k, rom_addr, k); end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL next_rdy_fetch%0d got=%b exp=0", k, cmd_ready); end
            step();
            n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL next_rdy_load%0d got=%b exp=0", k, cmd_ready); end
            step();
            n_cmp++; if (note_div !== NBASE + 20'(k)) begin n_bad++; $display("FAIL next_note%0d got=%h exp=%h", k, note_div, NBASE + 20'(k)); end
        end
        do_cmd(CMD_NEXT);
        cmd_valid = 1'b1; cmd = CMD_STOP;
        step();
        n_cmp++; if (dut.r_state !== ST_LOAD) begin n_bad++; $display("FAIL fetch_cmd_blocked got=%0d exp=%0d", dut.r_state, ST_LOAD); end
        step();
        cmd_valid = 1'b0;
        n_cmp++; if (note_div !== NBASE + 20'd7) begin n_bad++; $display("FAIL load_cmd_blocked got=%h exp=%h", note_div, NBASE + 20'd7); end
        tick = 1'b1; cmd_valid = 1'b1; cmd = CMD_STOP;
        step();
        tick = 1'b0; cmd_valid = 1'b0;
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_bad++; $display("FAIL stop_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL stop_addr got=%0d exp=0", rom_addr); end
        n_cmp++; if (note_div !== 20'd0) begin n_bad++; $display("FAIL stop_note got=%h exp=0", note_div); end
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL stop_playing got=%b exp=0", playing); end
        n_cmp++; if (dut.u_dur_cnt.r_count !== 8'd3) begin n_bad++; $display("FAIL stop_tick_dropped got=%0d exp=3", dut.u_dur_cnt.r_count); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 64; k++) rom[k] = '{WBASE + 20'(k), 8'd1};
        loop_en = 1'b0;
        apply_reset();
        do_cmd(CMD_PLAY); step(); step();
        for (int k = 1; k < 64; k++) begin
            do_cmd(CMD_NEXT); step(); step();
        end
        n_cmp++; if (note_div !== WBASE + 20'd63) begin n_bad++; $display("FAIL wrap_last got=%h exp=%h", note_div, WBASE + 20'd63); end
        do_tick(); do_tick();
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL wrap_addr got=%0d exp=0", rom_addr); end
        step(); step();
        n_cmp++; if (note_div !== WBASE) begin n_bad++; $display("FAIL wrap_first got=%h exp=%h", note_div, WBASE); end
    endtask

    task automatic test_loop();
        int pulses;
        clear_rom();
        loop_en = 1'b1;
        apply_reset();
        do_cmd(CMD_PLAY); step(); step();
        n_cmp++; if (dut.r_state !== ST_DONE) begin n_bad++; $display("FAIL empty_done got=%0d exp=%0d", dut.r_state, ST_DONE); end
        n_cmp++; if (song_done !== 1'b1) begin n_bad++; $display("FAIL empty_pulse got=%b exp=1", song_done); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (song_done === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL empty_extra_pulses got=%0d exp=0", pulses); end
        n_cmp++; if (dut.r_state !== ST_DONE) begin n_bad++; $display("FAIL empty_no_spin got=%0d exp=%0d", dut.r_state, ST_DONE); end
        rom[0] = '{NA, 8'd1};
        apply_reset();
        do_cmd(CMD_PLAY); step(); step();
        do_tick(); do_tick();
        step(); step();
        n_cmp++; if (dut.r_state !== ST_FETCH) begin n_bad++; $display("FAIL loop_refetch got=%0d exp=%0d", dut.r_state, ST_FETCH); end
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL loop_addr got=%0d exp=0", rom_addr); end
        n_cmp++; if (song_done !== 1'b0) begin n_bad++; $display("FAIL loop_no_done got=%b exp=0", song_done); end
        step(); step();
        n_cmp++; if (note_div !== NA) begin n_bad++; $display("FAIL loop_note got=%h exp=%h", note_div, NA); end
    endtask

    task automatic test_reset_mid_play();
        clear_rom();
        rom[0] = '{NA, 8'd9};
        loop_en = 1'b0;
        apply_reset();
        do_cmd(CMD_PLAY); step(); step(); do_tick();
        rst_n = 1'b0; tick = 1'b1; cmd_valid = 1'b1; cmd = CMD_NEXT;
        step();
        n_cmp++; if (note_div !== 20'd0) begin n_bad++; $display("FAIL midrst_note got=%h exp=0", note_div); end
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL midrst_playing got=%b exp=0", playing); end
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL midrst_addr got=%0d exp=0", rom_addr); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got=%b exp=1", cmd_ready); end
        n_cmp++; if (dut.u_dur_cnt.r_count !== 8'd0) begin n_bad++; $display("FAIL midrst_remain got=%0d exp=0", dut.u_dur_cnt.r_count); end
        rst_n = 1'b1; tick = 1'b0; cmd_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear_rom();
        test_reset();
        test_play_basic();
        test_pause_resume();
        test_stop_next();
        test_wrap();
        test_loop();
        test_reset_mid_play();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
